sim_dm_ram_param: RTL and testbench

Parametrised simulation data memory and successor to the fixed 3072x32 single-port data RAM.
- Port A is read/write with arbitrary per-byte write enables.
- Port B is a read-only port for debug or an instruction-side peek.
- Read-during-write mode and output pipelining are selectable.
- A reset-driven clear sequencer zeroes the array before use.
- Sits between the MEM stage of the pipeline and the test harness.

---
 rtl/sim_dm_ram_param.sv | 146 ++++++++++++++
 tb/tb_sim_dm_ram_param.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sim_dm_ram_param.sv
// Parametrised simulation data memory: port A read/write with byte enables, port B read-only,
// selectable read-during-write and output register, reset-driven clear sequencer.
module sim_dm_ram_param #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DEPTH        = 3072,
    parameter int unsigned RD_MODE      = 0,
    parameter int unsigned OUT_REG      = 0,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic                clka,
    input  logic                rsta,
    input  logic                ena,
    input  logic [DATA_W/8-1:0] wea,
    input  logic [ADDR_W-1:0]   addra,
    input  logic [DATA_W-1:0]   dina,
    output logic [DATA_W-1:0]   douta,
    input  logic                enb,
    input  logic [ADDR_W-1:0]   addrb,
    output logic [DATA_W-1:0]   doutb,
    output logic                init_done,
    output logic                addr_err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               init_done_q, init_done_d;
    logic               clr_we;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               run, req_a, req_b, in_a, in_b, we_a, hit_b;
    logic [IDX_W-1:0]   idx_a, idx_b;
    logic [DATA_W-1:0]  old_a, old_b, merged_a, rd_a, rd_b;

    logic [DATA_W-1:0]  douta_s1_q, douta_s1_d, douta_s2_q, douta_s2_d;
    logic [DATA_W-1:0]  doutb_s1_q, doutb_s1_d, doutb_s2_q, doutb_s2_d;
    logic               vld_a_s1_q, vld_a_s1_d, vld_b_s1_q, vld_b_s1_d;
    logic               err_s1_q, err_s1_d, err_s2_q, err_s2_d;

    // Clear sequencer next state
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (CLEAR_ON_RST != 0) begin
                    clr_we = 1'b1;
                    if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        clr_cnt_d = clr_cnt_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CLEAR;
        endcase
        init_done_d = (state_d == ST_RUN);
    end

    // Address decode; upper address bits take part in the range check
    always_comb begin
        run   = (state_q == ST_RUN);
        req_a = run && ena;
        req_b = run && enb;
        in_a  = ({1'b0, addra} < (ADDR_W + 1)'(DEPTH));
        in_b  = ({1'b0, addrb} < (ADDR_W + 1)'(DEPTH));
        idx_a = IDX_W'(addra);
        idx_b = IDX_W'(addrb);
        old_a = in_a ? mem[idx_a] : '0;
        old_b = in_b ? mem[idx_b] : '0;
        for (int i = 0; i < NB; i++) begin
            merged_a[8*i +: 8] = wea[i] ? dina[8*i +: 8] : old_a[8*i +: 8];
        end
        we_a  = req_a && in_a && (wea != '0);
        hit_b = we_a && (addrb == addra);
        rd_a  = !in_a ? '0 : ((RD_MODE != 0) ? merged_a : old_a);
        rd_b  = !in_b ? '0 : (((RD_MODE != 0) && hit_b) ? merged_a : old_b);
    end

    // Read pipeline; data stages hold when their port is idle, error is a pulse
    always_comb begin
        douta_s1_d = req_a ? rd_a : douta_s1_q;
        doutb_s1_d = req_b ? rd_b : doutb_s1_q;
        vld_a_s1_d = req_a;
        vld_b_s1_d = req_b;
        err_s1_d   = req_a && !in_a;
        douta_s2_d = vld_a_s1_q ? douta_s1_q : douta_s2_q;
        doutb_s2_d = vld_b_s1_q ? doutb_s1_q : doutb_s2_q;
        err_s2_d   = err_s1_q;
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            douta_s1_q  <= '0;
            doutb_s1_q  <= '0;
            douta_s2_q  <= '0;
            doutb_s2_q  <= '0;
            vld_a_s1_q  <= 1'b0;
            vld_b_s1_q  <= 1'b0;
            err_s1_q    <= 1'b0;
            err_s2_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            douta_s1_q  <= douta_s1_d;
            doutb_s1_q  <= doutb_s1_d;
            douta_s2_q  <= douta_s2_d;
            doutb_s2_q  <= doutb_s2_d;
            vld_a_s1_q  <= vld_a_s1_d;
            vld_b_s1_q  <= vld_b_s1_d;
            err_s1_q    <= err_s1_d;
            err_s2_q    <= err_s2_d;
        end
    end

    // Storage array has no reset; the sequencer zeroes it instead
    always_ff @(posedge clka) begin
        if (!rsta) begin
            if (clr_we) begin
                mem[clr_cnt_q] <= '0;
            end else if (we_a) begin
                mem[idx_a] <= merged_a;
            end
        end
    end

    assign douta     = (OUT_REG != 0) ? douta_s2_q : douta_s1_q;
    assign doutb     = (OUT_REG != 0) ? doutb_s2_q : doutb_s1_q;
    assign addr_err  = (OUT_REG != 0) ? err_s2_q : err_s1_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_sim_dm_ram_param.sv
// Directed bench for sim_dm_ram_param: three configurations share one stimulus stream
// (a: 16 words read-first, b: 16 words write-first registered, c: default 3072 words).
module tb_sim_dm_ram_param;

    logic        clk = 1'b0;
    logic        rsta;
    logic        ena, enb;
    logic [3:0]  wea;
    logic [11:0] addra, addrb;
    logic [31:0] dina;

    logic [31:0] a_douta, a_doutb, b_douta, b_doutb, c_douta, c_doutb;
    logic        a_init, b_init, c_init, a_err, b_err, c_err;

    int n_chk = 0;
    int n_bad = 0;
    int n;

    always #5 clk = ~clk;

    sim_dm_ram_param #(.DEPTH(16), .RD_MODE(0), .OUT_REG(0)) u_a (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(a_douta), .enb(enb), .addrb(addrb), .doutb(a_doutb),
        .init_done(a_init), .addr_err(a_err));

    sim_dm_ram_param #(.DEPTH(16), .RD_MODE(1), .OUT_REG(1)) u_b (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(b_douta), .enb(enb), .addrb(addrb), .doutb(b_doutb),
        .init_done(b_init), .addr_err(b_err));

    sim_dm_ram_param u_c (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(c_douta), .enb(enb), .addrb(addrb), .doutb(c_doutb),
        .init_done(c_init), .addr_err(c_err));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rsta = 1'b1; ena = 1'b0; enb = 1'b0; wea = '0;
        addra = '0; addrb = '0; dina = '0;
        tick; tick;
        chk("rst_init", 32'(a_init), 0);
        chk("rst_douta", a_douta, 0);
        chk("rst_err", 32'(a_err), 0);

        // Clear with port A hammering addr 2; reset again at clr_cnt = 8
        rsta = 1'b0; ena = 1'b1; wea = 4'hF; addra = 12'd2; dina = 32'hFFFF_FFFF;
        enb = 1'b1; addrb = 12'd2;
        repeat (8) tick;
        chk("mid_clear_init", 32'(a_init), 0);
        rsta = 1'b1;
        tick;
        rsta = 1'b0;
        n = 0;
        while (!a_init && n < 40) begin
            tick;
            n++;
        end
        ena = 1'b0; enb = 1'b0; wea = '0;
        chk("clear_cycles_a", 32'(n), 16);
        chk("clear_init_b", 32'(b_init), 1);
        chk("clear_init_c", 32'(c_init), 0);
        chk("clear_douta", a_douta, 0);
        chk("clear_doutb", a_doutb, 0);
        chk("clear_err", 32'(a_err), 0);
        while (!c_init && n < 4000) begin
            tick;
            n++;
        end
        chk("clear_cycles_c", 32'(n), 3072);

        // Every word reads back zero, including the one targeted during clear
        for (int i = 0; i < 16; i++) begin
            ena = 1'b1; addra = 12'(i);
            tick;
            chk($sformatf("clr_rd%0d", i), a_douta, 0);
        end
        ena = 1'b0;

        // Sparse byte enables
        ena = 1'b1; wea = 4'hF; addra = 12'd5; dina = 32'hAABB_CCDD;
        tick;
        wea = 4'b0101; dina = 32'h1122_3344;
        tick;
        chk("be_rdfirst_a", a_douta, 32'hAABB_CCDD);
        wea = '0;
        tick;
        chk("be_merge_a", a_douta, 32'hAA22_CC44);
        ena = 1'b0;
        tick;
        chk("be_hold_a", a_douta, 32'hAA22_CC44);
        chk("be_merge_b", b_douta, 32'hAA22_CC44);

        // Read during write on both ports
        ena = 1'b1; wea = 4'hF; addra = 12'd7; dina = 32'h1;
        tick;
        dina = 32'h2; enb = 1'b1; addrb = 12'd7;
        tick;
        chk("rdw_douta_a", a_douta, 32'h1);
        chk("rdw_doutb_a", a_doutb, 32'h1);
        chk("rdw_douta_b_prev", b_douta, 32'h1);
        ena = 1'b0; enb = 1'b0; wea = '0;
        tick;
        chk("rdw_douta_b", b_douta, 32'h2);
        chk("rdw_doutb_b", b_doutb, 32'h2);

        // Two-cycle latency with back-to-back reads
        ena = 1'b1; wea = 4'hF; addra = 12'd3; dina = 32'hDEAD_BEEF;
        tick;
        addra = 12'd4; dina = 32'h1234_5678;
        tick;
        wea = '0; addra = 12'd3; enb = 1'b1; addrb = 12'd3;
        tick;
        chk("lat_b_edge1", b_douta, 32'h1234_5678);
        chk("lat_a_edge1", a_douta, 32'hDEAD_BEEF);
        addra = 12'd4; addrb = 12'd4;
        tick;
        chk("lat_b_edge2", b_douta, 32'hDEAD_BEEF);
        chk("lat_bb_edge2", b_doutb, 32'hDEAD_BEEF);
        chk("lat_a_next", a_douta, 32'h1234_5678);
        ena = 1'b0; enb = 1'b0;
        tick;
        chk("lat_b_edge3", b_douta, 32'h1234_5678);
        chk("lat_bb_edge3", b_doutb, 32'h1234_5678);

        // Out-of-range write, then read of addr 0
        ena = 1'b1; wea = 4'hF; addra = 12'd0; dina = 32'hCAFE_F00D;
        tick;
        addra = 12'd3072; dina = 32'hFFFF_FFFF;
        tick;
        chk("oor_err_c", 32'(c_err), 1);
        chk("oor_douta_c", c_douta, 0);
        chk("oor_err_a", 32'(a_err), 1);
        chk("oor_douta_a", a_douta, 0);
        wea = '0; addra = 12'd0; enb = 1'b1; addrb = 12'd4000;
        tick;
        chk("oor_err_clr_c", 32'(c_err), 0);
        chk("oor_mem0_c", c_douta, 32'hCAFE_F00D);
        chk("oor_mem0_a", a_douta, 32'hCAFE_F00D);
        chk("oor_err_b", 32'(b_err), 1);
        chk("oor_douta_b", b_douta, 0);
        chk("oor_doutb_c", c_doutb, 0);
        ena = 1'b0; enb = 1'b0;
        tick;
        chk("oor_err_clr_b", 32'(b_err), 0);
        chk("oor_mem0_b", b_douta, 32'hCAFE_F00D);
        chk("oor_err_idle_c", 32'(c_err), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
